// File: rtl/mem_req_arbiter_if.sv
// Request/response bundle between the two cache clients, the arbiter and main memory.
interface mem_req_arbiter_if #(
   parameter int unsigned NUM_CLIENTS = 2,
   parameter int unsigned NUM_TAGS    = 15,
   parameter int unsigned ADDR_BITS   = 32
);
   localparam int unsigned TAG_BITS = $clog2(NUM_TAGS + 1);

   logic [NUM_CLIENTS-1:0]           req_valid;
   logic [NUM_CLIENTS*ADDR_BITS-1:0] req_addr;
   logic [NUM_CLIENTS-1:0]           req_accepted;
   logic [TAG_BITS-1:0]              req_tag;
   logic [1:0]                       mem_command;
   logic [ADDR_BITS-1:0]             mem_addr;
   logic [TAG_BITS-1:0]              mem_resp_tag;
   logic [TAG_BITS-1:0]              mem_data_tag;
   logic [NUM_CLIENTS-1:0]           resp_valid;
   logic [TAG_BITS-1:0]              outstanding_cnt;
   logic                             err_stray_tag;

   // Arbiter side
   modport slave (
      input  req_valid, req_addr, mem_resp_tag, mem_data_tag,
      output req_accepted, req_tag, mem_command, mem_addr,
             resp_valid, outstanding_cnt, err_stray_tag
   );

   // Client/memory environment side
   modport master (
      output req_valid, req_addr, mem_resp_tag, mem_data_tag,
      input  req_accepted, req_tag, mem_command, mem_addr,
             resp_valid, outstanding_cnt, err_stray_tag
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares the main-memory request port between D-cache (client 0) and I-cache (client 1),
// tracks tag ownership and steers returning data beats back to the owning client.
module mem_req_arbiter #(
   parameter int unsigned NUM_CLIENTS  = 2,
   parameter int unsigned NUM_TAGS     = 15,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned ADDR_BITS    = 32
) (
   input  logic                clock,
   input  logic                reset,
   mem_req_arbiter_if.slave    bus
);
   localparam int unsigned TAG_BITS  = $clog2(NUM_TAGS + 1);
   localparam int unsigned CID_BITS  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int unsigned WAIT_BITS = $clog2(STARVE_LIMIT + 1);
   localparam logic [1:0]  MEM_NONE  = 2'd0;
   localparam logic [1:0]  MEM_LOAD  = 2'd1;

   logic [NUM_TAGS-1:0]  owner_valid_q, owner_valid_d;
   logic [CID_BITS-1:0]  owner_id_q [NUM_TAGS];
   logic [CID_BITS-1:0]  owner_id_d [NUM_TAGS];
   logic [WAIT_BITS-1:0] wait_cnt_q [NUM_CLIENTS];
   logic [WAIT_BITS-1:0] wait_cnt_d [NUM_CLIENTS];
   logic [TAG_BITS-1:0]  outstanding_q, outstanding_d;
   logic                 err_q, err_d;

   logic                   win_valid, starve_found, issue, accept;
   logic [CID_BITS-1:0]    win_id, starve_id;
   logic [ADDR_BITS-1:0]   addr_arr [NUM_CLIENTS];
   logic [NUM_CLIENTS-1:0] accepted_c, resp_c;
   logic [TAG_BITS-1:0]    ret_idx, acc_idx;
   logic                   ret_hit, ret_stray;

   // Grant, issue and return steering; outputs are forced low while reset is asserted
   always_comb begin
      win_valid    = 1'b0;
      win_id       = '0;
      starve_found = 1'b0;
      starve_id    = '0;
      accepted_c   = '0;
      resp_c       = '0;
      for (int i = int'(NUM_CLIENTS) - 1; i >= 0; i--) begin
         addr_arr[i] = bus.req_addr[i*ADDR_BITS +: ADDR_BITS];
         if (bus.req_valid[i]) begin
            win_valid = 1'b1;
            win_id    = CID_BITS'(i);
            if (wait_cnt_q[i] == WAIT_BITS'(STARVE_LIMIT)) begin
               starve_found = 1'b1;
               starve_id    = CID_BITS'(i);
            end
         end
      end
      if (starve_found) win_id = starve_id;

      issue  = reset && win_valid && (outstanding_q < TAG_BITS'(NUM_TAGS));
      accept = issue && (bus.mem_resp_tag != '0);
      for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
         accepted_c[i] = accept && (win_id == CID_BITS'(i));
      end

      ret_idx   = bus.mem_data_tag - TAG_BITS'(1);
      acc_idx   = bus.mem_resp_tag - TAG_BITS'(1);
      ret_hit   = reset && (bus.mem_data_tag != '0) && owner_valid_q[ret_idx];
      ret_stray = reset && (bus.mem_data_tag != '0) && !ret_hit;
      for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
         resp_c[i] = ret_hit && (owner_id_q[ret_idx] == CID_BITS'(i));
      end
   end

   assign bus.req_accepted    = accepted_c;
   assign bus.req_tag         = accept ? bus.mem_resp_tag : '0;
   assign bus.mem_command     = issue ? MEM_LOAD : MEM_NONE;
   assign bus.mem_addr        = issue ? addr_arr[win_id] : '0;
   assign bus.resp_valid      = resp_c;
   assign bus.outstanding_cnt = outstanding_q;
   assign bus.err_stray_tag   = err_q;

   // Next state: return clears its entry before a same-cycle accept sets it again
   always_comb begin
      owner_valid_d = owner_valid_q;
      owner_id_d    = owner_id_q;
      outstanding_d = outstanding_q + TAG_BITS'(accept) - TAG_BITS'(ret_hit);
      err_d         = err_q | ret_stray;
      if (ret_hit) owner_valid_d[ret_idx] = 1'b0;
      if (accept) begin
         owner_valid_d[acc_idx] = 1'b1;
         owner_id_d[acc_idx]    = win_id;
      end
      for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
         if (bus.req_valid[i] && !accepted_c[i]) begin
            wait_cnt_d[i] = (wait_cnt_q[i] == WAIT_BITS'(STARVE_LIMIT)) ?
                            wait_cnt_q[i] : wait_cnt_q[i] + WAIT_BITS'(1);
         end else begin
            wait_cnt_d[i] = '0;
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         owner_valid_q <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
         for (int t = 0; t < int'(NUM_TAGS); t++) owner_id_q[t] <= '0;
         for (int i = 0; i < int'(NUM_CLIENTS); i++) wait_cnt_q[i] <= '0;
      end else begin
         owner_valid_q <= owner_valid_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
         for (int t = 0; t < int'(NUM_TAGS); t++) owner_id_q[t] <= owner_id_d[t];
         for (int i = 0; i < int'(NUM_CLIENTS); i++) wait_cnt_q[i] <= wait_cnt_d[i];
      end
   end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a behavioural tag-ownership model checked every cycle.
module tb_mem_req_arbiter;
   localparam logic [31:0] A0 = 32'h0000_1000;
   localparam logic [31:0] A1 = 32'h0000_2040;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   bit   started;

   mem_req_arbiter_if #(.NUM_CLIENTS(2), .NUM_TAGS(15), .ADDR_BITS(32)) bus ();

   mem_req_arbiter #(.NUM_CLIENTS(2), .NUM_TAGS(15), .STARVE_LIMIT(4), .ADDR_BITS(32)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: owner per tag (-1 = free), wait per client, count, sticky error
   int m_owner [16];
   int m_wait  [2];
   int m_cnt;
   bit m_err;
   int win, e_acc, e_tag, e_cmd, e_resp, dt, rt;
   bit e_issue, e_accept;
   logic [31:0] e_addr;

   initial begin
      for (int t = 0; t < 16; t++) m_owner[t] = -1;
      m_wait[0] = 0; m_wait[1] = 0; m_cnt = 0; m_err = 0;
   end

   always @(posedge clk) if (!rst_n) started = 1'b1;

   always @(negedge clk) begin
      if (started) begin
         dt = int'(bus.mem_data_tag);
         rt = int'(bus.mem_resp_tag);
         win = -1;
         for (int i = 0; i < 2; i++) if (win < 0 && bus.req_valid[i] && m_wait[i] == 4) win = i;
         for (int i = 0; i < 2; i++) if (win < 0 && bus.req_valid[i]) win = i;
         e_issue  = rst_n && win >= 0 && m_cnt < 15;
         e_accept = e_issue && rt != 0;
         e_acc    = e_accept ? (1 << win) : 0;
         e_tag    = e_accept ? rt : 0;
         e_cmd    = e_issue ? 1 : 0;
         e_addr   = e_issue ? ((win == 0) ? A0 : A1) : 32'h0;
         e_resp   = (rst_n && dt != 0 && m_owner[dt] >= 0) ? (1 << m_owner[dt]) : 0;

         chk("model req_accepted", 32'(bus.req_accepted), 32'(e_acc));
         chk("model req_tag", 32'(bus.req_tag), 32'(e_tag));
         chk("model mem_command", 32'(bus.mem_command), 32'(e_cmd));
         chk("model mem_addr", bus.mem_addr, e_addr);
         chk("model resp_valid", 32'(bus.resp_valid), 32'(e_resp));
         chk("model outstanding_cnt", 32'(bus.outstanding_cnt), 32'(m_cnt));
         chk("model err_stray_tag", 32'(bus.err_stray_tag), 32'(m_err));

         // Advance the model to the state after the coming posedge
         if (!rst_n) begin
            for (int t = 0; t < 16; t++) m_owner[t] = -1;
            m_wait[0] = 0; m_wait[1] = 0; m_cnt = 0; m_err = 0;
         end else begin
            if (dt != 0) begin
               if (m_owner[dt] >= 0) begin
                  m_owner[dt] = -1;
                  m_cnt--;
               end else begin
                  m_err = 1;
               end
            end
            if (e_accept) begin
               m_owner[rt] = win;
               m_cnt++;
            end
            for (int i = 0; i < 2; i++) begin
               if (bus.req_valid[i] && !(e_accept && win == i))
                  m_wait[i] = (m_wait[i] < 4) ? m_wait[i] + 1 : 4;
               else
                  m_wait[i] = 0;
            end
         end
      end
   end

   // Apply one input vector just after a rising edge, then wait for the sampling edge
   task automatic drive(input logic r, input logic [1:0] rv, input int rtag, input int dtag);
      @(posedge clk);
      #1;
      rst_n            = r;
      bus.req_valid    = rv;
      bus.mem_resp_tag = 4'(rtag);
      bus.mem_data_tag = 4'(dtag);
      @(negedge clk);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      started = 1'b0;
      rst_n            = 1'b0;
      bus.req_valid    = '0;
      bus.req_addr     = {A1, A0};
      bus.mem_resp_tag = '0;
      bus.mem_data_tag = '0;

      // 1: reset for three cycles, then idle
      repeat (3) drive(1'b0, 2'b00, 0, 0);
      drive(1'b1, 2'b00, 0, 0);
      chk("t1 req_accepted", 32'(bus.req_accepted), 32'd0);
      chk("t1 mem_command", 32'(bus.mem_command), 32'd0);
      chk("t1 mem_addr", bus.mem_addr, 32'd0);
      chk("t1 resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("t1 outstanding_cnt", 32'(bus.outstanding_cnt), 32'd0);
      chk("t1 err_stray_tag", 32'(bus.err_stray_tag), 32'd0);

      // 2: both valid, client 0 wins with tag 3, then tag 3 returns
      drive(1'b1, 2'b11, 3, 0);
      chk("t2 req_accepted", 32'(bus.req_accepted), 32'b01);
      chk("t2 req_tag", 32'(bus.req_tag), 32'd3);
      chk("t2 mem_addr", bus.mem_addr, A0);
      chk("t2 mem_command", 32'(bus.mem_command), 32'd1);
      drive(1'b1, 2'b00, 0, 0);
      chk("t2 count one", 32'(bus.outstanding_cnt), 32'd1);
      drive(1'b1, 2'b00, 0, 3);
      chk("t2 resp_valid", 32'(bus.resp_valid), 32'b01);
      drive(1'b1, 2'b00, 0, 0);
      chk("t2 count zero", 32'(bus.outstanding_cnt), 32'd0);

      // 3: client 1 promoted on its fifth waiting cycle
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, 2'b11, k, 0);
         chk($sformatf("t3 grant cycle %0d", k), 32'(bus.req_accepted), (k == 5) ? 32'b10 : 32'b01);
      end
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, 2'b00, 0, k);
         chk($sformatf("t3 return tag %0d", k), 32'(bus.resp_valid), (k == 5) ? 32'b10 : 32'b01);
      end
      drive(1'b1, 2'b00, 0, 0);
      chk("t3 count drained", 32'(bus.outstanding_cnt), 32'd0);

      // 4: fill all 15 tags, throttle, then resume after one return
      for (int k = 1; k <= 15; k++) drive(1'b1, 2'b01, k, 0);
      drive(1'b1, 2'b01, 9, 4);
      chk("t4 count full", 32'(bus.outstanding_cnt), 32'd15);
      chk("t4 throttled command", 32'(bus.mem_command), 32'd0);
      chk("t4 throttled accept", 32'(bus.req_accepted), 32'd0);
      chk("t4 return while full", 32'(bus.resp_valid), 32'b01);
      drive(1'b1, 2'b01, 4, 0);
      chk("t4 count after return", 32'(bus.outstanding_cnt), 32'd14);
      chk("t4 issue resumes", 32'(bus.mem_command), 32'd1);
      chk("t4 reused tag", 32'(bus.req_tag), 32'd4);
      drive(1'b1, 2'b00, 0, 0);
      chk("t4 count refilled", 32'(bus.outstanding_cnt), 32'd15);
      for (int k = 1; k <= 15; k++) drive(1'b1, 2'b00, 0, k);
      drive(1'b1, 2'b00, 0, 0);
      chk("t4 count drained", 32'(bus.outstanding_cnt), 32'd0);

      // 5: tag 7 returns to client 0 while re-accepted for client 1
      drive(1'b1, 2'b01, 7, 0);
      drive(1'b1, 2'b10, 7, 7);
      chk("t5 old owner resp", 32'(bus.resp_valid), 32'b01);
      chk("t5 new accept", 32'(bus.req_accepted), 32'b10);
      chk("t5 req_tag", 32'(bus.req_tag), 32'd7);
      drive(1'b1, 2'b00, 0, 0);
      chk("t5 count unchanged", 32'(bus.outstanding_cnt), 32'd1);
      drive(1'b1, 2'b00, 0, 7);
      chk("t5 new owner resp", 32'(bus.resp_valid), 32'b10);
      drive(1'b1, 2'b00, 0, 0);
      chk("t5 count zero", 32'(bus.outstanding_cnt), 32'd0);

      // 6: reset drops tag 5 ownership; its late return is stray and sticky
      drive(1'b1, 2'b01, 5, 0);
      drive(1'b0, 2'b10, 2, 0);
      chk("t6 accept gated in reset", 32'(bus.req_accepted), 32'd0);
      chk("t6 command gated in reset", 32'(bus.mem_command), 32'd0);
      chk("t6 count before edge", 32'(bus.outstanding_cnt), 32'd1);
      drive(1'b1, 2'b00, 0, 0);
      chk("t6 count cleared", 32'(bus.outstanding_cnt), 32'd0);
      drive(1'b1, 2'b00, 0, 5);
      chk("t6 stray resp", 32'(bus.resp_valid), 32'd0);
      chk("t6 err not yet", 32'(bus.err_stray_tag), 32'd0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 2'b00, 0, 0);
         chk("t6 err sticky", 32'(bus.err_stray_tag), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
